// File: rtl/muldiv.sv
// Multiply/divide unit owning the HI/LO write port: single-cycle MTHI/MTLO merge,
// registered 32x32 multiply, and a 32-iteration radix-2 restoring divider.
module muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [63:0] hilo_cur,
  input  logic        flush,
  output logic        busy,
  output logic        hilo_we,
  output logic [63:0] hilo_wdata
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic        sgn_q, sgn_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;
  logic        hilo_we_q, hilo_we_d;
  logic [63:0] hilo_wdata_q, hilo_wdata_d;

  logic        accept;
  logic        is_signed_div;
  logic [31:0] a_mag, b_mag;
  logic [32:0] rem_shift;
  logic        sub_ok;
  logic [31:0] sub_val;
  logic [63:0] ax, bx, prod;
  logic [31:0] q_fix, r_fix;

  assign busy       = (state_q != S_IDLE);
  assign hilo_we    = hilo_we_q;
  assign hilo_wdata = hilo_wdata_q;

  assign accept        = start && (state_q == S_IDLE) && !flush && (op <= OP_MTLO);
  assign is_signed_div = (op == OP_DIV);
  assign a_mag         = (is_signed_div && a[31]) ? -a : a;
  assign b_mag         = (is_signed_div && b[31]) ? -b : b;

  // Remainder shifted left with the next dividend bit; when it covers the
  // divisor the 32-bit difference is exact because the result is below 2^32.
  assign rem_shift = {rem_q, quo_q[31]};
  assign sub_ok    = (rem_shift >= {1'b0, b_q});
  assign sub_val   = rem_shift[31:0] - b_q;

  // Extending both operands to 64 bits makes one multiplier serve MULT and MULTU.
  assign ax   = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign bx   = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign prod = ax * bx;

  assign q_fix = qneg_q ? -quo_q : quo_q;
  assign r_fix = rneg_q ? -rem_q : rem_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    sgn_d        = sgn_q;
    qneg_d       = qneg_q;
    rneg_d       = rneg_q;
    dz_d         = dz_q;
    hilo_we_d    = 1'b0;
    hilo_wdata_d = hilo_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_MTHI: begin
              hilo_we_d    = 1'b1;
              hilo_wdata_d = {a, hilo_cur[31:0]};
            end
            OP_MTLO: begin
              hilo_we_d    = 1'b1;
              hilo_wdata_d = {hilo_cur[63:32], a};
            end
            OP_MULT, OP_MULTU: begin
              a_d     = a;
              b_d     = b;
              sgn_d   = (op == OP_MULT);
              state_d = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              a_d     = a;
              b_d     = b_mag;
              quo_d   = a_mag;
              rem_d   = 32'd0;
              cnt_d   = 6'd0;
              qneg_d  = is_signed_div && (a[31] ^ b[31]);
              rneg_d  = is_signed_div && a[31];
              dz_d    = (b == 32'd0);
              state_d = S_DIV;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        hilo_we_d    = 1'b1;
        hilo_wdata_d = prod;
        state_d      = S_IDLE;
      end
      S_DIV: begin
        rem_d = sub_ok ? sub_val : rem_shift[31:0];
        quo_d = {quo_q[30:0], sub_ok};
        if (cnt_q == 6'd31) begin
          cnt_d   = 6'd0;
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_FIX: begin
        hilo_we_d    = 1'b1;
        hilo_wdata_d = dz_q ? {a_q, 32'hFFFF_FFFF} : {r_fix, q_fix};
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // An aborted operation must never reach the write port.
    if (flush) begin
      state_d      = S_IDLE;
      cnt_d        = 6'd0;
      hilo_we_d    = 1'b0;
      hilo_wdata_d = hilo_wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 6'd0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      rem_q        <= 32'd0;
      quo_q        <= 32'd0;
      sgn_q        <= 1'b0;
      qneg_q       <= 1'b0;
      rneg_q       <= 1'b0;
      dz_q         <= 1'b0;
      hilo_we_q    <= 1'b0;
      hilo_wdata_q <= 64'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      sgn_q        <= sgn_d;
      qneg_q       <= qneg_d;
      rneg_q       <= rneg_d;
      dz_q         <= dz_d;
      hilo_we_q    <= hilo_we_d;
      hilo_wdata_q <= hilo_wdata_d;
    end
  end

endmodule
